pipelined_claa: RTL and testbench
=================================

Name: pipelined_claa

Overview:
- Parametrised successor to the 4-bit carry-lookahead adder.
- Adds or subtracts WIDTH-bit operands using a chain of GROUP-bit lookahead groups, with one pipeline register stage per group, so the carry crosses exactly one group per cycle.
- Sits in the datapath as a streaming ALU adder with valid/ready handshakes on both sides and NZVC status flags.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of GROUP and at least GROUP.
- GROUP, 4, bits per lookahead group; the number of stages is NS = WIDTH/GROUP.

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- RST_N  in  1  reset, synchronous and active-low.
- IN_VALID  in  1  operand set is valid.
- IN_READY  out  1  the block accepts the operand set this cycle.
- X  in  WIDTH  operand A.
- Y  in  WIDTH  operand B.
- C0  in  1  carry-in when SUB=0; borrow-in when SUB=1.
- SUB  in  1  0: F=X+Y+C0; 1: F=X-Y-C0.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts the result.
- F  out  WIDTH  result.
- COUT  out  1  carry out of the MSB; for SUB, 1 means no borrow.
- OV  out  1  signed overflow.
- Z  out  1  F equals 0.
- N  out  1  F[WIDTH-1].

Behaviour:
- Reset (RST_N=0 at a rising edge): all stage valid bits are cleared. OUT_VALID=0, F=0, COUT=0, OV=0, Z=0, N=0.
  - In-flight operations are discarded (mid-operation flush).
  - IN_READY=1 in the first cycle after reset.
- Operand conditioning at accept:
  - Yeff = SUB ? ~Y : Y.
  - Cin = SUB ? ~C0 : C0.
  - Hence SUB=1 computes X + ~Y + ~C0 = X - Y - C0 mod 2^WIDTH.
- Global stall:
  - adv = ~OUT_VALID | OUT_READY.
  - IN_READY = adv, combinational from OUT_VALID and OUT_READY only; it does not depend on IN_VALID.
  - All stages advance together when adv=1 and hold when adv=0.
- Accept: an operand set is taken when IN_VALID & IN_READY.
  - A cycle with IN_VALID=0 and adv=1 inserts a bubble (stage valid=0).
- Stage k (k = 0..NS-1):
  - Computes group k of the result with 4-bit-style generate/propagate lookahead: Gi=Xi&Yeff_i, Pi=Xi^Yeff_i, carries in parallel from the group carry-in.
  - Group carry-in: Cin for k=0; the registered carry of stage k-1 for k>0.
  - Stage k registers: the result bits of groups 0..k, the group carry-out, and the unconsumed operand bits of groups k+1..NS-1 (delay-aligned).
  - It also registers the carry into the MSB, needed for OV.
- Output: the final stage's registers drive F/COUT/OV/Z/N directly.
  - OV = carry into MSB XOR COUT. Z = (F==0). N = F[WIDTH-1].
- Latency: NS cycles from the accept edge to OUT_VALID=1, with no stall (4 cycles for 16/4).
- Throughput: one result per cycle when OUT_READY=1.
- Hold: while OUT_VALID=1 & OUT_READY=0, F and the flags are stable and no stage changes.
- Simultaneous events:
  - Accept and output handoff in the same cycle are both legal.
  - Results exit in accept order; none is dropped or duplicated.
- Wrap-around: arithmetic is mod 2^WIDTH; a full-width carry ripple still takes NS cycles, with no extra latency.
- NS=1: degenerates to a single registered CLA with latency 1.

Test Plan:
(WIDTH=16, GROUP=4 unless stated)
- Hold RST_N=0 for 3 cycles with IN_VALID=1 -> OUT_VALID=0, F=0, all flags 0, IN_READY=1 after release; assert RST_N=0 while 2 operations are in flight -> both are lost, OUT_VALID=0 on the next cycle.
- X=0x1234, Y=0x4321, C0=0, SUB=0 -> exactly 4 cycles later F=0x5555, COUT=0, OV=0, Z=0, N=0; X=0x0000, Y=0x0000, C0=1 -> F=0x0001.
- X=0xFFFF, Y=0x0001, C0=0, SUB=0 -> F=0x0000, COUT=1, Z=1, OV=0 (carry crosses all 4 groups); X=0x7FFF, Y=0x0001 -> F=0x8000, OV=1, N=1, COUT=0.
- SUB=1: X=0x0005, Y=0x0007, C0=0 -> F=0xFFFE, COUT=0, N=1; X=0x8000, Y=0x0001, C0=0 -> F=0x7FFF, OV=1, COUT=1; X=0x0010, Y=0x0003, C0=1 -> F=0x000C.
- Stream 8 random operand sets back-to-back with OUT_READY=0 for 3 cycles mid-stream -> IN_READY=0 exactly while OUT_VALID=1 & OUT_READY=0, F held stable, all 8 results match the reference model in order, none lost or duplicated.
- Rerun scenarios 2-4 with WIDTH=32, GROUP=4 (latency 8) and WIDTH=8, GROUP=8 (latency 1) -> results match the mod-2^WIDTH model.

Source files
------------

// File: rtl/pipelined_claa.sv
// Pipelined carry-lookahead adder/subtractor with NZVC flags.
// WIDTH must be a multiple of GROUP (and at least GROUP).
// One register stage per GROUP-bit lookahead group, so the carry crosses
// one group per cycle. Stage k holds result groups 0..k plus the operand
// groups still waiting for their carry. All stages share one global stall.
module pipelined_claa #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             C0,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] F,
  output logic             COUT,
  output logic             OV,
  output logic             Z,
  output logic             N
);
  localparam int NS = WIDTH / GROUP;

  // Carry into bit i of a group, written as a flat sum of products
  // (Gj & Pj+1..Pi-1 terms plus P0..Pi-1 & ci) so it maps to parallel lookahead.
  function automatic logic grp_carry(input logic [GROUP-1:0] a, input logic [GROUP-1:0] b,
                                     input logic ci, input int i);
    logic acc, pp;
    acc = 1'b0;
    pp  = 1'b1;
    for (int j = GROUP - 1; j >= 0; j--) begin
      if (j < i) begin
        acc = acc | (a[j] & b[j] & pp);
        pp  = pp & (a[j] ^ b[j]);
      end
    end
    return acc | (pp & ci);
  endfunction

  function automatic logic [GROUP-1:0] grp_sum(input logic [GROUP-1:0] a, input logic [GROUP-1:0] b,
                                               input logic ci);
    logic [GROUP-1:0] s;
    for (int i = 0; i < GROUP; i++)
      s[i] = a[i] ^ b[i] ^ grp_carry(a, b, ci, i);
    return s;
  endfunction

  logic             adv;
  logic [NS:0]      vld_pipe;
  logic [WIDTH-1:0] y_eff;
  logic             c_in0;

  // Subtraction is X + ~Y + ~C0; the borrow-in becomes an inverted carry-in.
  assign y_eff       = SUB ? ~Y : Y;
  assign c_in0       = C0 ^ SUB;
  assign adv         = ~OUT_VALID | OUT_READY;
  assign IN_READY    = adv;
  assign vld_pipe[0] = IN_VALID;
  assign OUT_VALID   = vld_pipe[NS];
  assign Z           = OUT_VALID & ~|F;
  assign N           = F[WIDTH-1];

  // Stage valid bits move together; a cycle without IN_VALID injects a bubble.
  always_ff @(posedge CLK) begin
    if (!RST_N)   vld_pipe[NS:1] <= '0;
    else if (adv) vld_pipe[NS:1] <= vld_pipe[NS-1:0];
  end

  for (genvar k = 0; k < NS; k++) begin : g_st
    // Operand bits not yet summed; this stage's group sits at the bottom.
    logic [(NS-k)*GROUP-1:0] xs, ys;
    logic                    ci;
    logic [(k+1)*GROUP-1:0]  f_nxt, f_r;
    logic                    c_r;

    if (k == 0) begin : g_head
      assign xs    = X;
      assign ys    = y_eff;
      assign ci    = c_in0;
      assign f_nxt = grp_sum(xs[GROUP-1:0], ys[GROUP-1:0], ci);
    end else begin : g_body
      assign xs    = g_st[k-1].g_fwd.x_r;
      assign ys    = g_st[k-1].g_fwd.y_r;
      assign ci    = g_st[k-1].c_r;
      assign f_nxt = {grp_sum(xs[GROUP-1:0], ys[GROUP-1:0], ci), g_st[k-1].f_r};
    end

    // Latch the partial result and this group's carry-out.
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        f_r <= '0;
        c_r <= 1'b0;
      end else if (adv) begin
        f_r <= f_nxt;
        c_r <= grp_carry(xs[GROUP-1:0], ys[GROUP-1:0], ci, GROUP);
      end
    end

    if (k < NS - 1) begin : g_fwd
      logic [(NS-1-k)*GROUP-1:0] x_r, y_r;

      // Delay the remaining operand groups so they meet their carry.
      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          x_r <= '0;
          y_r <= '0;
        end else if (adv) begin
          x_r <= xs[(NS-k)*GROUP-1:GROUP];
          y_r <= ys[(NS-k)*GROUP-1:GROUP];
        end
      end
    end else begin : g_tail
      logic cm_r;

      // Carry into the MSB, kept only in the last stage for overflow.
      always_ff @(posedge CLK) begin
        if (!RST_N)   cm_r <= 1'b0;
        else if (adv) cm_r <= grp_carry(xs[GROUP-1:0], ys[GROUP-1:0], ci, GROUP - 1);
      end

      assign F    = f_r;
      assign COUT = c_r;
      assign OV   = cm_r ^ c_r;
    end
  end
endmodule

// File: tb/tb_pipelined_claa.sv
// Directed bench for pipelined_claa: 16/4 main instance plus 32/4 and 8/8.
module tb_pipelined_claa;
  logic clk = 1'b0;
  logic rst_n, in_valid, sub, c0, out_ready;

  logic [15:0] x16, y16, f16;
  logic        rdy16, vld16, co16, ovf16, z16, n16;
  logic [31:0] x32, y32, f32;
  logic        rdy32, vld32, co32, ovf32, z32, n32;
  logic [7:0]  x8, y8, f8;
  logic        rdy8, vld8, co8, ovf8, z8, n8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipelined_claa #(.WIDTH(16), .GROUP(4)) u16 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(rdy16), .X(x16), .Y(y16),
    .C0(c0), .SUB(sub), .OUT_VALID(vld16), .OUT_READY(out_ready), .F(f16), .COUT(co16),
    .OV(ovf16), .Z(z16), .N(n16));

  pipelined_claa #(.WIDTH(32), .GROUP(4)) u32 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(rdy32), .X(x32), .Y(y32),
    .C0(c0), .SUB(sub), .OUT_VALID(vld32), .OUT_READY(out_ready), .F(f32), .COUT(co32),
    .OV(ovf32), .Z(z32), .N(n32));

  pipelined_claa #(.WIDTH(8), .GROUP(8)) u8 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(rdy8), .X(x8), .Y(y8),
    .C0(c0), .SUB(sub), .OUT_VALID(vld8), .OUT_READY(out_ready), .F(f8), .COUT(co8),
    .OV(ovf8), .Z(z8), .N(n8));

  typedef struct {
    logic [15:0] x, y;
    logic        c0, sub;
    logic [15:0] f;
    logic        cout, ov, z, n;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: {ov, cout, f} for a w-bit add/sub
  function automatic logic [65:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic c, input logic s, input int w);
    logic [63:0] mask, ye, sm, f;
    logic co, ov;
    mask = (64'h1 << w) - 64'h1;
    ye   = (s ? ~y : y) & mask;
    sm   = (x & mask) + ye + {63'h0, c ^ s};
    f    = sm & mask;
    co   = sm[w];
    ov   = (x[w-1] == ye[w-1]) && (f[w-1] != x[w-1]);
    return {ov, co, f};
  endfunction

  // Pack {ov, cout, z, n, f} for a w-bit reference result
  function automatic logic [63:0] exp_pack(input logic [65:0] r, input int w);
    logic [63:0] f;
    f = r[63:0];
    return ({60'h0, r[65], r[64], (f == 64'h0), f[w-1]} << w) | f;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    logic [15:0] sx[8], sy[8];
    logic        ss[8], sc[8];
    logic [19:0] expq[$];
    logic [19:0] held;
    logic        stall_prev, acc, s16, s32, s8;
    int          idx, got;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset held 3 cycles with IN_VALID high
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; sub = 1'b0; c0 = 1'b0;
    x16 = 16'h1234; y16 = 16'h4321; x32 = '0; y32 = '0; x8 = '0; y8 = '0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("reset_state", {vld16, f16, co16, ovf16, z16, n16}, '0);
    end
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0; #1;
    chk("ready_after_reset", rdy16, 1);

    // Two ops in flight, then reset: both must vanish
    @(negedge clk); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("flush_out_valid", vld16, 0);
    end

    // Single-shot vectors on all three widths, latency checked per instance
    for (int i = 0; i < 8; i++) begin
      logic [65:0] e32, e8;
      @(negedge clk);
      in_valid = 1'b1; sub = tbl[i].sub; c0 = tbl[i].c0;
      x16 = tbl[i].x; y16 = tbl[i].y;
      x32 = {tbl[i].x, tbl[i].x}; y32 = {tbl[i].y, tbl[i].y};
      x8 = tbl[i].x[7:0]; y8 = tbl[i].y[7:0];
      e32 = ref_add({32'h0, x32}, {32'h0, y32}, c0, sub, 32);
      e8  = ref_add({56'h0, x8}, {56'h0, y8}, c0, sub, 8);
      s16 = 1'b0; s32 = 1'b0; s8 = 1'b0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
        @(posedge clk); #1;
        if (cyc == 1) in_valid = 1'b0;
        if (vld16 && !s16) begin
          s16 = 1'b1;
          chk("lat16", cyc, 4);
          chk("res16", {ovf16, co16, z16, n16, f16},
              {tbl[i].ov, tbl[i].cout, tbl[i].z, tbl[i].n, tbl[i].f});
        end
        if (vld32 && !s32) begin
          s32 = 1'b1;
          chk("lat32", cyc, 8);
          chk("res32", {ovf32, co32, z32, n32, f32}, exp_pack(e32, 32));
        end
        if (vld8 && !s8) begin
          s8 = 1'b1;
          chk("lat8", cyc, 1);
          chk("res8", {ovf8, co8, z8, n8, f8}, exp_pack(e8, 8));
        end
      end
      chk("seen_all", {s16, s32, s8}, 3'b111);
    end

    // Back-to-back stream on the 16-bit instance with a 3-cycle output stall
    for (int i = 0; i < 8; i++) begin
      sx[i] = 16'($urandom); sy[i] = 16'($urandom);
      ss[i] = 1'($urandom); sc[i] = 1'($urandom);
    end
    idx = 0; got = 0; stall_prev = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      if (stall_prev) chk("hold_stable", {ovf16, co16, z16, n16, f16}, held);
      out_ready = !(cyc >= 4 && cyc < 7);
      if (idx < 8) begin
        in_valid = 1'b1; x16 = sx[idx]; y16 = sy[idx]; sub = ss[idx]; c0 = sc[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("in_ready", rdy16, !(vld16 && !out_ready));
      stall_prev = vld16 && !out_ready;
      if (stall_prev) held = {ovf16, co16, z16, n16, f16};
      if (vld16 && out_ready) begin
        if (expq.size() == 0) chk("stream_extra", 1, 0);
        else chk("stream_res", {ovf16, co16, z16, n16, f16}, expq.pop_front());
        got++;
      end
      acc = in_valid && rdy16;
      @(posedge clk);
      if (acc) begin
        expq.push_back(20'(exp_pack(ref_add({48'h0, x16}, {48'h0, y16}, c0, sub, 16), 16)));
        idx++;
      end
    end
    in_valid = 1'b0;
    chk("stream_count", got, 8);
    chk("stream_leftover", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
